axi_lite_arbiter: RTL

- Shares one AXI4-lite master port between the instruction fetch unit (read-only requester) and the load/store unit (read/write requester).
- Both requesters use the level-start / pulse-finish handshake: the requester holds req high until it sees done for one cycle, then drops req.
- Sits between IFU/LSU and the memory-side AXI4-lite slave.
- Round-robin arbitration, one outstanding transaction at a time.

---
 rtl/axi_lite_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter
// Shares one AXI4-lite master port between the instruction fetch unit
// (read-only) and the load/store unit (read/write). Both requesters use a
// level-start / pulse-finish handshake: req is held until a one-cycle done.
// Arbitration is round-robin with a single outstanding transaction.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           IFU read request and fetch address
//   if_rdata/if_done/if_err  32-bit fetched word, completion pulse, rresp[1]
//   ls_req/ls_we/ls_addr     LSU request, write enable, address
//   ls_wdata/ls_wstrb        LSU write data and byte strobes
//   ls_rdata/ls_done/ls_err  LSU read data, completion pulse, resp[1]
//   m_ar*, m_r*              AXI read address / read data channels
//   m_aw*, m_w*, m_b*        AXI write address / write data / response
module axi_lite_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [31:0]         if_rdata,
  output logic                if_done,
  output logic                if_err,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_done,
  output logic                ls_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

  state_e              state_q, state_d;
  logic                grant_ls_q, grant_ls_d;
  logic                last_ls_q, last_ls_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                take_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                resp_err_q;
  logic [31:0]         if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;
  logic                unused_resp;

  // Only the error bit of each response is reported back to the requesters.
  assign unused_resp = m_rresp[0] ^ m_bresp[0];

  // Next-state logic. In IDLE a tie goes to whichever requester was not
  // granted last; a lone request is granted directly. IFU grants are always
  // reads, so ls_we only matters when the LSU wins.
  always_comb begin
    state_d    = state_q;
    grant_ls_d = grant_ls_q;
    last_ls_d  = last_ls_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    take_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          take_grant = 1'b1;
          grant_ls_d = (if_req && ls_req) ? !last_ls_q : ls_req;
          last_ls_d  = grant_ls_d;
          state_d    = (grant_ls_d && ls_we) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: if (m_arready) state_d = RD_DATA;
      RD_DATA: if (m_rvalid) state_d = DONE;
      WR_REQ: begin
        // Address and data handshakes complete independently, possibly in
        // the same cycle; the flags remember which ones already landed.
        if (m_awready) aw_done_d = 1'b1;
        if (m_wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: if (m_bvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant bookkeeping, request latching and response capture.
  // After reset the LSU counts as last granted so the IFU wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_ls_q <= 1'b0;
      last_ls_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      resp_err_q <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_ls_q <= grant_ls_d;
      last_ls_q  <= last_ls_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      if (take_grant) begin
        addr_q  <= grant_ls_d ? ls_addr  : if_addr;
        wdata_q <= grant_ls_d ? ls_wdata : '0;
        wstrb_q <= grant_ls_d ? ls_wstrb : '0;
      end
      if (state_q == RD_DATA && m_rvalid) begin
        resp_err_q <= m_rresp[1];
        // The IFU sees the 32-bit half selected by address bit 2.
        if (grant_ls_q) ls_rdata_q <= m_rdata;
        else            if_rdata_q <= addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
      end
      if (state_q == WR_RESP && m_bvalid) resp_err_q <= m_bresp[1];
    end
  end

  // Valids are decoded from state so an asynchronous reset drops them at once.
  assign m_araddr  = addr_q;
  assign m_arvalid = (state_q == RD_ADDR);
  assign m_rready  = (state_q == RD_DATA);
  assign m_awaddr  = addr_q;
  assign m_awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign m_bready  = (state_q == WR_RESP);

  assign if_done  = (state_q == DONE) && !grant_ls_q;
  assign ls_done  = (state_q == DONE) &&  grant_ls_q;
  assign if_err   = if_done && resp_err_q;
  assign ls_err   = ls_done && resp_err_q;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;

endmodule
